// File: rtl/loop_mem_sequencer.sv
// loop_mem_sequencer: per-frame SRAM bank sweep with background zero-fill and overrun flag.
// Define READ_TIMEOUT_EN to abandon stalled reads and expose a sticky rd_timeout output.
module loop_mem_sequencer #(
  parameter int NUM_BANKS  = 16,
  parameter int ADDR_W     = 22,
  parameter int WR_CYCLES  = 62,
  parameter int RD_TIMEOUT = 255,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                 clk_100MHz,
  input  logic                 rst,
  input  logic                 pulse,
  input  logic [NUM_BANKS-1:0] playing,
  input  logic [NUM_BANKS-1:0] recording,
  input  logic                 rd_valid,
  input  logic                 clr_req,
  input  logic [BANK_W-1:0]    clr_bank,
  input  logic [ADDR_W-1:0]    max_block,
  output logic                 clr_done,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n,
  output logic                 write_zero,
  output logic                 get_data,
  output logic                 data_ready,
  output logic                 mix_data,
  output logic                 overrun,
  output logic [ADDR_W-1:0]    block_addr,
  output logic [ADDR_W-1:0]    mem_block_addr,
  output logic [BANK_W-1:0]    mem_bank
`ifdef READ_TIMEOUT_EN
  ,
  output logic                 rd_timeout
`endif
);
  localparam int CNT_MAX = WR_CYCLES > RD_TIMEOUT ? WR_CYCLES : RD_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  typedef enum logic [3:0] {IDLE, SLOT, WR, RD, DONE, MIX, CLR_SET, CLR_WR, CLR_INC} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] clr_addr, clr_limit;
  logic clr_act, pend;
  assign mem_block_addr = write_zero ? clr_addr : block_addr;
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      clr_addr <= '0;
      clr_limit <= '0;
      clr_act <= 1'b0;
      pend <= 1'b0;
      clr_done <= 1'b0;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      write_zero <= 1'b0;
      get_data <= 1'b0;
      data_ready <= 1'b0;
      mix_data <= 1'b0;
      overrun <= 1'b0;
      block_addr <= '0;
      mem_bank <= '0;
`ifdef READ_TIMEOUT_EN
      rd_timeout <= 1'b0;
`endif
    end else begin
      get_data <= 1'b0;
      data_ready <= 1'b0;
      mix_data <= 1'b0;
      clr_done <= 1'b0;
      overrun <= pulse && !(state inside {IDLE, CLR_SET, CLR_WR, CLR_INC});
      case (state)
        IDLE: begin
          mem_bank <= '0;
          cnt <= '0;
          pend <= 1'b0;
          if (pulse) state <= SLOT;
          else if (clr_req) begin
            mem_bank <= clr_bank;
            write_zero <= clr_act;
            state <= clr_act ? CLR_WR : CLR_SET;
          end else begin
            // a paused clear whose request went away is forgotten
            clr_act <= 1'b0;
            clr_addr <= '0;
            clr_limit <= '0;
          end
        end
        SLOT: begin
          cnt <= '0;
          if (recording[mem_bank]) begin
            get_data <= 1'b1;
            ram_ce_n <= 1'b0;
            ram_oe_n <= 1'b1;
            state <= WR;
          end else if (playing[mem_bank]) begin
            ram_ce_n <= 1'b0;
            ram_oe_n <= 1'b0;
            state <= RD;
          end else begin
            data_ready <= 1'b1;
            state <= DONE;
          end
        end
        WR: begin
          if (cnt == CNT_W'(WR_CYCLES)) begin
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            cnt <= '0;
            data_ready <= 1'b1;
            state <= DONE;
          end else begin
            ram_we_n <= 1'b0;
            cnt <= cnt + 1'b1;
          end
        end
        RD: begin
`ifdef READ_TIMEOUT_EN
          if (rd_valid || cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            rd_timeout <= rd_timeout | !rd_valid;
`else
          if (rd_valid) begin
`endif
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            cnt <= '0;
            data_ready <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + 1'b1;
        end
        DONE: begin
          if (mem_bank == BANK_W'(NUM_BANKS - 1)) begin
            mix_data <= 1'b1;
            state <= MIX;
          end else begin
            mem_bank <= mem_bank + 1'b1;
            state <= SLOT;
          end
        end
        MIX: begin
          block_addr <= !(|(playing | recording)) ? '0 :
                        (max_block != '0 && block_addr >= max_block) ? '0 : block_addr + 1'b1;
          mem_bank <= '0;
          state <= IDLE;
        end
        CLR_SET: begin
          clr_limit <= max_block != '0 ? max_block : block_addr;
          clr_addr <= '0;
          clr_act <= 1'b1;
          write_zero <= 1'b1;
          mem_bank <= clr_bank;
          pend <= pend | pulse;
          cnt <= '0;
          state <= CLR_WR;
        end
        CLR_WR: begin
          pend <= pend | pulse;
          if (cnt == CNT_W'(WR_CYCLES)) begin
            ram_ce_n <= 1'b1;
            ram_we_n <= 1'b1;
            cnt <= '0;
            state <= CLR_INC;
          end else begin
            ram_ce_n <= 1'b0;
            ram_we_n <= 1'b0;
            cnt <= cnt + 1'b1;
          end
        end
        CLR_INC: begin
          pend <= 1'b0;
          if (clr_addr == clr_limit) begin
            clr_done <= 1'b1;
            write_zero <= 1'b0;
            clr_addr <= '0;
            clr_limit <= '0;
            clr_act <= 1'b0;
            mem_bank <= '0;
            state <= (pend | pulse) ? SLOT : IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
            // a frame tick parks the clear; clr_addr is kept for the resume
            if (pend | pulse) begin
              write_zero <= 1'b0;
              mem_bank <= '0;
              state <= SLOT;
            end else state <= CLR_WR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loop_mem_sequencer.sv
// tb_loop_mem_sequencer: directed bench with block-address and zero-fill scoreboards.
module tb_loop_mem_sequencer;
  logic clk_100MHz = 1'b0;
  logic rst = 1'b1, pulse = 1'b0, rd_valid = 1'b0, clr_req = 1'b0;
  logic [15:0] playing = '0, recording = '0;
  logic [3:0] clr_bank = '0;
  logic [21:0] max_block = '0;
  logic clr_done, ram_ce_n, ram_oe_n, ram_we_n, write_zero, get_data, data_ready, mix_data, overrun;
  logic [21:0] block_addr, mem_block_addr;
  logic [3:0] mem_bank;
`ifdef READ_TIMEOUT_EN
  logic rd_timeout;
`endif
  always #5 clk_100MHz = ~clk_100MHz;
  loop_mem_sequencer dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .pulse(pulse), .playing(playing), .recording(recording),
    .rd_valid(rd_valid), .clr_req(clr_req), .clr_bank(clr_bank), .max_block(max_block),
    .clr_done(clr_done), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .write_zero(write_zero), .get_data(get_data), .data_ready(data_ready), .mix_data(mix_data),
    .overrun(overrun), .block_addr(block_addr), .mem_block_addr(mem_block_addr), .mem_bank(mem_bank)
`ifdef READ_TIMEOUT_EN
    , .rd_timeout(rd_timeout)
`endif
  );
  int passed = 0, failed = 0, total = 0;
  int n_get = 0, n_rdy = 0, n_mix = 0, n_ovr = 0, n_zw = 0, n_done = 0;
  int wl = 0, last_run = 0, rd_cd = 0;
  int ce_cnt[16];
  logic we_p = 1'b1, ce_p = 1'b1, oe_p = 1'b1, mix_pend = 1'b0;
  int addr_q[$];
  int zq[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: observe outputs, run scoreboards, answer reads
  task automatic tick();
    @(posedge clk_100MHz);
    #1;
    if (get_data) n_get++;
    if (data_ready) n_rdy++;
    if (overrun) n_ovr++;
    if (clr_done) n_done++;
    if (mix_pend) begin
      mix_pend = 1'b0;
      if (addr_q.size() == 0) chk("unexpected_mix", 32'(block_addr), 32'hffff_ffff);
      else chk("block_addr", 32'(block_addr), addr_q.pop_front());
    end
    if (mix_data) begin
      n_mix++;
      mix_pend = 1'b1;
    end
    if (!ram_we_n && we_p && write_zero) begin
      n_zw++;
      if (zq.size() == 0) chk("unexpected_zero_wr", 32'(mem_block_addr), 32'hffff_ffff);
      else chk("zero_wr_addr", 32'(mem_block_addr), zq.pop_front());
      chk("zero_wr_bank", 32'(mem_bank), 32'(clr_bank));
    end
    if (!ram_we_n) wl++;
    else if (!we_p) begin
      last_run = wl;
      wl = 0;
    end
    if (!ram_ce_n && ce_p) ce_cnt[mem_bank]++;
    rd_valid = 1'b0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) rd_valid = 1'b1;
    end
    if (!ram_oe_n && oe_p) rd_cd = 5;
    we_p = ram_we_n;
    ce_p = ram_ce_n;
    oe_p = ram_oe_n;
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic pulse1();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    tick();
  endtask
  task automatic wait_mix(input int tgt);
    for (int k = 0; k < 5000 && n_mix < tgt; k++) tick();
    if (n_mix < tgt) chk("wait_mix_timeout", 32'(n_mix), 32'(tgt));
  endtask
  task automatic wait_done(input int tgt);
    for (int k = 0; k < 5000 && n_done < tgt; k++) tick();
    if (n_done < tgt) chk("wait_clr_done_timeout", 32'(n_done), 32'(tgt));
  endtask
  task automatic wait_zw(input int tgt);
    for (int k = 0; k < 5000 && n_zw < tgt; k++) tick();
    if (n_zw < tgt) chk("wait_zero_wr_timeout", 32'(n_zw), 32'(tgt));
  endtask
  initial begin
    int b_get, b_rdy, b_mix, b_ovr, b_zw, b_done;
    int ce0[16];
    int exp3[5] = '{1, 2, 3, 0, 1};
    int ce_sum;
    foreach (ce_cnt[i]) ce_cnt[i] = 0;
    run(3);
    chk("rst_ce_n", 32'(ram_ce_n), 1);
    chk("rst_oe_n", 32'(ram_oe_n), 1);
    chk("rst_we_n", 32'(ram_we_n), 1);
    chk("rst_block_addr", 32'(block_addr), 0);
    chk("rst_mem_block_addr", 32'(mem_block_addr), 0);
    chk("rst_mem_bank", 32'(mem_bank), 0);
    chk("rst_write_zero", 32'(write_zero), 0);
    chk("rst_flags", 32'({clr_done, get_data, data_ready, mix_data, overrun}), 0);
    rst = 1'b0;
    run(2);
    // single recording bank
    b_get = n_get; b_rdy = n_rdy; b_mix = n_mix; ce0 = ce_cnt;
    recording = 16'h0001;
    addr_q.push_back(1);
    pulse1();
    wait_mix(b_mix + 1);
    run(3);
    chk("rec_get_data", 32'(n_get - b_get), 1);
    chk("rec_we_low_cycles", 32'(last_run), 62);
    chk("rec_data_ready", 32'(n_rdy - b_rdy), 16);
    chk("rec_mix_data", 32'(n_mix - b_mix), 1);
    chk("rec_ce_bank0", 32'(ce_cnt[0] - ce0[0]), 1);
    ce_sum = 0;
    foreach (ce_cnt[i]) ce_sum += ce_cnt[i] - ce0[i];
    chk("rec_ce_total", 32'(ce_sum), 1);
    // single playing bank 15
    b_get = n_get; b_rdy = n_rdy; b_mix = n_mix; ce0 = ce_cnt;
    recording = '0;
    playing = 16'h8000;
    addr_q.push_back(2);
    pulse1();
    wait_mix(b_mix + 1);
    run(3);
    chk("play_ce_bank15", 32'(ce_cnt[15] - ce0[15]), 1);
    ce_sum = 0;
    foreach (ce_cnt[i]) ce_sum += ce_cnt[i] - ce0[i];
    chk("play_ce_total", 32'(ce_sum), 1);
    chk("play_data_ready", 32'(n_rdy - b_rdy), 16);
    chk("play_mix_data", 32'(n_mix - b_mix), 1);
    chk("play_get_data", 32'(n_get - b_get), 0);
    // loop wrap at max_block
    do_reset();
    max_block = 22'd3;
    playing = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      b_mix = n_mix;
      addr_q.push_back(exp3[i]);
      pulse1();
      wait_mix(b_mix + 1);
      run(3);
    end
    chk("wrap_queue_drained", 32'(addr_q.size()), 0);
    // uninterrupted clear of bank 2
    do_reset();
    playing = '0;
    max_block = 22'd4;
    clr_bank = 4'd2;
    b_zw = n_zw; b_done = n_done;
    for (int i = 0; i < 5; i++) zq.push_back(i);
    clr_req = 1'b1;
    wait_done(b_done + 1);
    clr_req = 1'b0;
    run(5);
    chk("clr_zero_writes", 32'(n_zw - b_zw), 5);
    chk("clr_done_count", 32'(n_done - b_done), 1);
    chk("clr_queue_drained", 32'(zq.size()), 0);
    chk("clr_write_zero_off", 32'(write_zero), 0);
    chk("clr_we_low_cycles", 32'(last_run), 62);
    // clear pre-empted by a frame tick, then resumed
    do_reset();
    recording = 16'h0010;
    b_zw = n_zw; b_done = n_done; b_mix = n_mix; b_ovr = n_ovr;
    for (int i = 0; i < 5; i++) zq.push_back(i);
    addr_q.push_back(1);
    clr_req = 1'b1;
    wait_zw(b_zw + 2);
    pulse1();
    wait_mix(b_mix + 1);
    chk("pause_zero_writes", 32'(n_zw - b_zw), 2);
    wait_done(b_done + 1);
    clr_req = 1'b0;
    run(5);
    chk("resume_zero_writes", 32'(n_zw - b_zw), 5);
    chk("resume_clr_done", 32'(n_done - b_done), 1);
    chk("resume_mix_data", 32'(n_mix - b_mix), 1);
    chk("resume_no_overrun", 32'(n_ovr - b_ovr), 0);
    chk("resume_queue_drained", 32'(zq.size()), 0);
    // second tick mid-sweep
    do_reset();
    recording = 16'h0001;
    b_mix = n_mix; b_ovr = n_ovr;
    addr_q.push_back(1);
    pulse1();
    run(20);
    pulse1();
    wait_mix(b_mix + 1);
    run(50);
    chk("overrun_cycles", 32'(n_ovr - b_ovr), 1);
    chk("overrun_mix_data", 32'(n_mix - b_mix), 1);
    // reset in the middle of a write
    b_mix = n_mix; b_get = n_get;
    pulse1();
    run(10);
    chk("midwr_we_low", 32'(ram_we_n), 0);
    chk("midwr_block_addr_pre", 32'(block_addr), 1);
    rst = 1'b1;
    tick();
    chk("midwr_rst_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 3'b111);
    chk("midwr_rst_block_addr", 32'(block_addr), 0);
    chk("midwr_rst_mem_bank", 32'(mem_bank), 0);
    rst = 1'b0;
    run(100);
    chk("midwr_no_mix", 32'(n_mix - b_mix), 0);
    chk("midwr_get_data", 32'(n_get - b_get), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
